// File: rtl/mp_add_pkg.sv
// -----------------------------------------------------------------------------
// mp_add_pkg
// Shared definitions for the multi-precision sequential adder:
//   WORD_W      - datapath word width (fixed to match the carry-skip core)
//   state_t     - control FSM states
//   signed_ovf  - signed overflow from the carries into and out of the MSB
// -----------------------------------------------------------------------------
package mp_add_pkg;

   localparam int WORD_W = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,   // waiting for the first (least-significant) word
      ST_RUN  = 1'b1    // mid-operand, carry chained through carry_reg
   } state_t;

   // Two's-complement overflow: the carry into the sign bit differs from
   // the carry out of it.
   function automatic logic signed_ovf(input logic c15, input logic c16);
      return c15 ^ c16;
   endfunction

endpackage

// File: rtl/csk_word_add.sv
// -----------------------------------------------------------------------------
// csk_word_add
// Combinational WORD_W-bit carry-skip adder built from 4-bit blocks. Each block
// ripples internally; when every bit of a block propagates, the block's
// carry-in is forwarded directly to the next block.
// Ports:
//   a, b  in  WORD_W  addends
//   cin   in  1       carry into bit 0
//   sum   out WORD_W  a + b + cin (modulo 2^WORD_W)
//   c15   out 1       carry into the MSB (for signed overflow)
//   c16   out 1       carry out of the MSB
// -----------------------------------------------------------------------------
module csk_word_add
   import mp_add_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   input  logic              cin,
   output logic [WORD_W-1:0] sum,
   output logic              c15,
   output logic              c16
);

   localparam int BLK_W = 4;
   localparam int N_BLK = WORD_W / BLK_W;

   logic [WORD_W-1:0] prop;
   logic [WORD_W-1:0] gen;
   logic [N_BLK-1:0]  grp_prop;
   logic [WORD_W-1:0] bit_cin;

   genvar gi;
   generate
      for (gi = 0; gi < N_BLK; gi++) begin : g_blk
         assign prop[gi*BLK_W +: BLK_W] = a[gi*BLK_W +: BLK_W] ^ b[gi*BLK_W +: BLK_W];
         assign gen[gi*BLK_W +: BLK_W]  = a[gi*BLK_W +: BLK_W] & b[gi*BLK_W +: BLK_W];
         assign grp_prop[gi]            = &prop[gi*BLK_W +: BLK_W];
      end
   endgenerate

   // Block carries are computed sequentially in one process so the skip
   // path and the intra-block ripple stay a single combinational chain.
   always_comb begin
      logic blk_c;
      logic rip;
      bit_cin = '0;
      c16     = 1'b0;
      blk_c   = cin;
      rip     = cin;
      for (int bi = 0; bi < N_BLK; bi++) begin
         rip = blk_c;
         for (int k = 0; k < BLK_W; k++) begin
            bit_cin[bi*BLK_W + k] = rip;
            rip = gen[bi*BLK_W + k] | (prop[bi*BLK_W + k] & rip);
         end
         // Skip: a fully propagating block passes its carry-in straight on.
         blk_c = grp_prop[bi] ? blk_c : rip;
      end
      c16 = blk_c;
   end

   assign sum = prop ^ bit_cin;
   assign c15 = bit_cin[WORD_W-1];

endmodule

// File: rtl/mp_seq_adder.sv
// -----------------------------------------------------------------------------
// mp_seq_adder
// Multi-precision sequential adder/subtractor. Wide operands arrive as a
// stream of 16-bit word pairs, least-significant word first; one registered
// sum word leaves per accepted pair, with the carry chained across cycles.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake
//   in_a, in_b          operand words
//   in_last             word is the operand MSW
//   in_sub, in_cin      mode and carry-in, sampled on the first word only
//   out_valid/out_ready output handshake
//   out_sum             result word
//   out_last            result word is the MSW
//   out_carry, out_ovf  final carry-out / signed overflow (MSW only)
//   out_err             operand was cut off at MAX_WORDS (MSW only)
//   busy                mid-operand
// -----------------------------------------------------------------------------
module mp_seq_adder
   import mp_add_pkg::*;
#(
   parameter int MAX_WORDS = 8
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_a,
   input  logic [WORD_W-1:0] in_b,
   input  logic              in_last,
   input  logic              in_sub,
   input  logic              in_cin,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_sum,
   output logic              out_last,
   output logic              out_carry,
   output logic              out_ovf,
   output logic              out_err,
   output logic              busy
);

   localparam int CNT_W = $clog2(MAX_WORDS) + 1;

   state_t            state_reg;
   logic              carry_reg;
   logic              sub_reg;
   logic [CNT_W-1:0]  word_cnt_reg;

   logic              out_valid_reg;
   logic [WORD_W-1:0] out_sum_reg;
   logic              out_last_reg;
   logic              out_carry_reg;
   logic              out_ovf_reg;
   logic              out_err_reg;

   logic              xfer;
   logic              first_word;
   logic              sub_eff;
   logic [WORD_W-1:0] b_eff;
   logic              add_cin;
   logic [WORD_W-1:0] sum_w;
   logic              c15_w;
   logic              c16_w;
   logic [CNT_W-1:0]  word_cnt_next;
   logic              forced_end;
   logic              word_last;

   // Single-entry output register: a new word may enter in the same cycle
   // the held one drains.
   assign in_ready   = !out_valid_reg || out_ready;
   assign xfer       = in_valid && in_ready;

   assign first_word = (state_reg == ST_IDLE);
   assign sub_eff    = first_word ? in_sub : sub_reg;
   assign b_eff      = sub_eff ? ~in_b : in_b;
   // Subtraction is A + ~B + 1; the +1 enters as the first word's carry-in.
   assign add_cin    = first_word ? (in_sub ? 1'b1 : in_cin) : carry_reg;

   assign word_cnt_next = first_word ? CNT_W'(1) : word_cnt_reg + CNT_W'(1);
   assign forced_end    = (word_cnt_next == CNT_W'(MAX_WORDS)) && !in_last;
   assign word_last     = in_last || forced_end;

   csk_word_add u_csk (
      .a   (in_a),
      .b   (b_eff),
      .cin (add_cin),
      .sum (sum_w),
      .c15 (c15_w),
      .c16 (c16_w)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         carry_reg     <= 1'b0;
         sub_reg       <= 1'b0;
         word_cnt_reg  <= '0;
         out_valid_reg <= 1'b0;
         out_sum_reg   <= '0;
         out_last_reg  <= 1'b0;
         out_carry_reg <= 1'b0;
         out_ovf_reg   <= 1'b0;
         out_err_reg   <= 1'b0;
      end else begin
         if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
         end
         if (xfer) begin
            out_valid_reg <= 1'b1;
            out_sum_reg   <= sum_w;
            out_last_reg  <= word_last;
            out_carry_reg <= word_last ? c16_w : 1'b0;
            out_ovf_reg   <= word_last ? signed_ovf(c15_w, c16_w) : 1'b0;
            out_err_reg   <= forced_end;
            word_cnt_reg  <= word_cnt_next;
            if (first_word) begin
               sub_reg <= in_sub;
            end
            if (word_last) begin
               state_reg <= ST_IDLE;
               carry_reg <= 1'b0;
            end else begin
               state_reg <= ST_RUN;
               carry_reg <= c16_w;
            end
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign out_sum   = out_sum_reg;
   assign out_last  = out_last_reg;
   assign out_carry = out_carry_reg;
   assign out_ovf   = out_ovf_reg;
   assign out_err   = out_err_reg;
   assign busy      = (state_reg == ST_RUN);

endmodule

// File: tb/tb_mp_seq_adder.sv
// -----------------------------------------------------------------------------
// tb_mp_seq_adder
// Directed and random streams against mp_seq_adder. Expected result words are
// queued as stimulus is issued and popped by an output monitor on each output
// transfer. Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mp_seq_adder;

   typedef struct packed {
      logic [15:0] sum;
      logic        last;
      logic        carry;
      logic        ovf;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        in_last;
   logic        in_sub;
   logic        in_cin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_sum;
   logic        out_last;
   logic        out_carry;
   logic        out_ovf;
   logic        out_err;
   logic        busy;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t exp_q[$];
   bit   rand_ready = 1'b0;

   // Reference model state for randomly generated operands.
   bit          m_run   = 1'b0;
   bit          m_sub   = 1'b0;
   bit          m_carry = 1'b0;
   int          m_cnt   = 0;

   mp_seq_adder #(.MAX_WORDS(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_last   (in_last),
      .in_sub    (in_sub),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_last  (out_last),
      .out_carry (out_carry),
      .out_ovf   (out_ovf),
      .out_err   (out_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Output monitor: a word is accepted at the next rising edge whenever
   // out_valid and out_ready are both high at the falling edge.
   always @(negedge clk) begin
      exp_t e;
      exp_t got;
      if (!rst && out_valid && out_ready) begin
         got = '{out_sum, out_last, out_carry, out_ovf, out_err};
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_output: got sum=%h last=%b, nothing expected", out_sum, out_last);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               n_bad++;
               $display("FAIL result_word: got sum=%h last=%b carry=%b ovf=%b err=%b, want sum=%h last=%b carry=%b ovf=%b err=%b",
                        got.sum, got.last, got.carry, got.ovf, got.err,
                        e.sum, e.last, e.carry, e.ovf, e.err);
            end else begin
               $display("ok   word sum=%h last=%b carry=%b ovf=%b err=%b",
                        got.sum, got.last, got.carry, got.ovf, got.err);
            end
         end
      end
   end

   // Random downstream backpressure, only during the random phase.
   always @(posedge clk) begin
      if (rand_ready) begin
         #1 out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Drive one word pair and hold it until accepted. Entered and left 1 time
   // unit after a rising edge.
   task automatic send_word(input logic [15:0] a, input logic [15:0] b,
                            input logic last, input logic sub, input logic cin);
      int waited = 0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_last  = last;
      in_sub   = sub;
      in_cin   = cin;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         waited++;
         if (waited > 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, want 1", waited);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Spec-level reference: plain 17-bit arithmetic for each accepted word.
   task automatic model_push(input logic [15:0] a, input logic [15:0] b,
                             input logic last, input logic sub, input logic cin);
      bit          first;
      bit          s;
      logic [15:0] be;
      logic        ci;
      logic [16:0] full;
      logic [15:0] low;
      bit          forced;
      bit          lst;
      first  = !m_run;
      s      = first ? sub : m_sub;
      be     = s ? ~b : b;
      ci     = first ? (sub ? 1'b1 : cin) : m_carry;
      full   = {1'b0, a} + {1'b0, be} + {16'd0, ci};
      low    = {1'b0, a[14:0]} + {1'b0, be[14:0]} + {15'd0, ci};
      m_cnt  = first ? 1 : m_cnt + 1;
      forced = (m_cnt == 8) && !last;
      lst    = last || forced;
      exp_q.push_back('{full[15:0], lst, lst ? full[16] : 1'b0,
                        lst ? (low[15] ^ full[16]) : 1'b0, forced});
      if (first) m_sub = sub;
      m_run   = !lst;
      m_carry = lst ? 1'b0 : full[16];
   endtask

   task automatic drain(input int cycles);
      out_ready = 1'b1;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
      in_sub = 1'b0; in_cin = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({out_valid, in_ready, busy, out_sum, out_last, out_carry, out_ovf, out_err} !== {1'b0, 1'b1, 1'b0, 16'h0, 4'b0}) begin
         n_bad++;
         $display("FAIL reset_state: got valid=%b ready=%b busy=%b sum=%h flags=%b%b%b%b, want 0 1 0 0000 0000",
                  out_valid, in_ready, busy, out_sum, out_last, out_carry, out_ovf, out_err);
      end else $display("ok   reset state");
      @(posedge clk);
      #1;
   endtask

   task automatic test_single_add();
      exp_q.push_back('{16'h0000, 1'b1, 1'b1, 1'b0, 1'b0});
      send_word(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0);
      // Result must be valid one cycle after the transfer.
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL latency: got out_valid=%b one cycle after transfer, want 1", out_valid);
      end else $display("ok   latency 1 cycle");
      @(posedge clk);
      #1;
      drain(2);
   endtask

   task automatic test_two_word_add();
      exp_q.push_back('{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0});
      exp_q.push_back('{16'h0002, 1'b1, 1'b0, 1'b0, 1'b0});
      send_word(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      send_word(16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0);
      drain(3);
   endtask

   task automatic test_two_word_sub();
      exp_q.push_back('{16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0});
      exp_q.push_back('{16'h0000, 1'b1, 1'b1, 1'b0, 1'b0});
      send_word(16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0);
      // in_sub deasserted on the second word must be ignored.
      send_word(16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
      drain(3);
   endtask

   task automatic test_overflow();
      exp_q.push_back('{16'h8000, 1'b1, 1'b0, 1'b1, 1'b0});
      send_word(16'h7FFF, 16'h0001, 1'b1, 1'b0, 1'b0);
      drain(3);
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      exp_q.push_back('{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0});
      exp_q.push_back('{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0});
      exp_q.push_back('{16'h0001, 1'b1, 1'b0, 1'b0, 1'b0});
      send_word(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0000; in_last = 1'b0;
      repeat (3) begin
         @(negedge clk);
         n_cmp++;
         if ({in_ready, out_valid, out_sum, busy} !== {1'b0, 1'b1, 16'h0000, 1'b1}) begin
            n_bad++;
            $display("FAIL stall_hold: got ready=%b valid=%b sum=%h busy=%b, want 0 1 0000 1",
                     in_ready, out_valid, out_sum, busy);
         end else $display("ok   stall cycle holds output");
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      send_word(16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0);
      send_word(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
      drain(3);
   endtask

   task automatic test_overrun();
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back('{16'h0000, i == 7, i == 7, 1'b0, i == 7});
         send_word(16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1);
      end
      // Ninth word must start a new operand, so its in_cin counts.
      exp_q.push_back('{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0});
      send_word(16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL overrun_restart_busy: got busy=%b, want 1", busy);
      end else $display("ok   fresh operand after overrun");
      @(posedge clk);
      #1;
      exp_q.push_back('{16'h0001, 1'b1, 1'b0, 1'b0, 1'b0});
      send_word(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
      drain(3);
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      send_word(16'h1234, 16'h0001, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      n_cmp++;
      if ({out_valid, busy} !== 2'b00) begin
         n_bad++;
         $display("FAIL reset_mid: got out_valid=%b busy=%b, want 0 0", out_valid, busy);
      end else $display("ok   reset mid-operand drops output");
      @(posedge clk);
      #1 out_ready = 1'b1;
      exp_q.push_back('{16'h0003, 1'b1, 1'b0, 1'b0, 1'b0});
      send_word(16'h0001, 16'h0001, 1'b1, 1'b0, 1'b1);
      drain(3);
   endtask

   task automatic test_back_to_back();
      m_run = 1'b0; m_carry = 1'b0; m_cnt = 0; m_sub = 1'b0;
      rand_ready = 1'b1;
      for (int op = 0; op < 20; op++) begin
         int          len;
         logic        sub;
         logic        cin;
         logic [15:0] a;
         logic [15:0] b;
         len = $urandom_range(1, 8);
         sub = $urandom_range(0, 1);
         cin = $urandom_range(0, 1);
         for (int w = 0; w < len; w++) begin
            a = $urandom();
            b = $urandom();
            if ($urandom_range(0, 3) == 0) a = 16'hFFFF;
            model_push(a, b, w == len - 1, (w == 0) ? sub : ~sub, cin);
            send_word(a, b, w == len - 1, (w == 0) ? sub : ~sub, cin);
         end
      end
      rand_ready = 1'b0;
      @(posedge clk);
      #2;
      drain(4);
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_two_word_add();
      test_two_word_sub();
      test_overflow();
      test_backpressure();
      test_overrun();
      test_reset_mid();
      test_back_to_back();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_empty: got %0d outstanding words, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
